multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Control unit for the multicycle RV32I core, replacing the single-cycle main/ALU decoder pair. A state register sequences each instruction through fetch, decode, execute, memory and writeback. It drives the shared-memory datapath's enables and muxes, stalls on a memory-ready handshake, and adds bne/blt/bge/bltu/bgeu, jalr, lui and the full RV32I ALU set. It also reports illegal opcodes and instruction retirement.

## Interface
- ALUCTRL_W, 4: ALUControl width, ≥4; bits above [3] driven 0.
- MEM_WAIT_EN, 1: 1 = honour MemReady; 0 = MemReady treated as constant 1.
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- OP6_0 / funct3_2_0 / funct7_5  in  7/3/1  fields from the instruction register.
- Zero, Negative, Overflow, Carry  in  1 each  ALU flags from the current cycle (Carry = no borrow on sub).
- MemReady  in  1  memory has completed the access presented this cycle.
- PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  out  1 each  datapath enables/select (AdrSrc 0 = PC, 1 = ALUOut).
- ResultSrc1_0  out  2  00 ALUOut, 01 read data, 10 ALU result direct.
- ALUSrcA1_0  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB1_0  out  2  00 rs2, 01 immediate, 10 constant 4.
- ImmSrc2_0  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUControl  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sll, 7 srl, 8 sra, 9 sltu.
- InstrDone, IllegalInstr  out  1 each  single-cycle pulses.
- State  out  4  current state (debug).

## Operation
- Only the 4-bit state register is sequential. Outputs are combinational from state, opcode, funct fields, flags and MemReady.
- Unlisted outputs in any state: enables 0, muxes 00, ALUControl add.
- States (encoding in brackets):
  - FETCH[0]: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, add, ResultSrc 10. IRWrite and PCWrite equal MemReady. Stays in FETCH until MemReady, then goes to DECODE.
  - DECODE[1]: ALUSrcA 01, ALUSrcB 01, add (ALUOut ← target). ImmSrc is J for opcode 1101111, B otherwise. Next state by opcode:
    - 0000011, 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI.
    - 1100011 → BRANCH; 1101111 → JUMP; 1100111 → JALR; 0110111 → LUI.
    - Branch with funct3 010/011, or any other opcode: IllegalInstr=1, → FETCH.
  - MEMADR[2]: ALUSrcA 10, ALUSrcB 01, add; ImmSrc S if OP6_0[5] else I. Goes to MEMWRITE if OP6_0[5], else MEMREAD.
  - MEMREAD[3]: AdrSrc 1. Holds until MemReady, then → MEMWB.
  - MEMWB[4]: ResultSrc 01, RegWrite, InstrDone, → FETCH.
  - MEMWRITE[5]: AdrSrc 1, MemWrite held high until MemReady. On MemReady: InstrDone, → FETCH.
  - EXECR[6]: ALUSrcA 10, ALUSrcB 00, funct decode → ALUWB.
  - EXECI[7]: as EXECR with ALUSrcB 01 and ImmSrc I → ALUWB.
  - ALUWB[8]: ResultSrc 00, RegWrite, InstrDone, → FETCH.
  - BRANCH[9]: ALUSrcA 10, ALUSrcB 00, sub, ResultSrc 00. PCWrite = condition. InstrDone, → FETCH.
  - JUMP[10]: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCWrite (PC ← target; ALUOut ← OldPC+4) → ALUWB.
  - JALR[11]: ALUSrcA 10, ALUSrcB 01, ImmSrc I, add → JUMP. The datapath clears bit 0 of the target.
  - LUI[12]: ALUSrcA 11, ALUSrcB 01, ImmSrc U, add → ALUWB.
  - Encodings 13-15: behave as FETCH with all enables 0, → FETCH.
- Funct decode (EXECR/EXECI), by funct3:
  - 000: sub if OP6_0[5]&funct7_5, else add. 001: sll. 010: slt. 011: sltu.
  - 100: xor. 101: sra if funct7_5, else srl. 110: or. 111: and.
- Branch condition, by funct3: 000 Zero; 001 !Zero; 100 N^V; 101 !(N^V); 110 !Carry; 111 Carry.

## Timing
- Cycles with zero wait states:
  - lw 5; sw, R, I, jal, lui 4; jalr 5; branch 3; illegal 2.
  - Each MemReady-low cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset: at the first edge with RST high, state ← FETCH.
  - While RST is high, all enables, InstrDone and IllegalInstr are forced 0; muxes and ALUControl are 0.
  - Reset mid-access (e.g. MemWrite high in MEMWRITE) aborts the access. The first cycle after RST falls is FETCH.
- MemReady high in a non-memory state is ignored.
- MEM_WAIT_EN=0: FETCH, MEMREAD and MEMWRITE each last exactly 1 cycle.
- InstrDone and IllegalInstr are never both high. Each pulses at most once per instruction.

## Test plan
- Reset then add x3,x1,x2 (OP 0110011, f3 000, f7_5 0), MemReady=1: State 0,1,6,8. ALUControl 0 in EXECR. RegWrite and InstrDone in cycle 4 only.
- sub (f7_5=1) vs addi with f7_5=1 (OP 0010011): ALUControl 1 vs 0. srai (f3 101, f7_5 1): ALUControl 8.
- lw with MemReady low 2 cycles in FETCH and 3 in MEMREAD: 10 cycles total. IRWrite/PCWrite only on the MemReady cycle. ResultSrc 01 with RegWrite in MEMWB.
- Branches: bne with Zero=1 → PCWrite 0; blt with N=1,V=0 → PCWrite 1; bgeu with Carry=0 → PCWrite 0. Each takes 3 cycles.
- jalr (OP 1100111): states 0,1,11,10,8. PCWrite in JUMP, RegWrite in ALUWB.
- OP 1111111: IllegalInstr in DECODE, back to FETCH. Reset asserted during MEMWRITE: MemWrite drops in the reset cycle, State=0 next.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: a 4-bit state register steps each instruction
// through fetch/decode/execute/memory/writeback. All outputs are combinational.
module multicycle_control_fsm #(
  parameter int unsigned ALUCTRL_W   = 4,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [6:0]           OP6_0,
  input  logic [2:0]           funct3_2_0,
  input  logic                 funct7_5,
  input  logic                 Zero,
  input  logic                 Negative,
  input  logic                 Overflow,
  input  logic                 Carry,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc1_0,
  output logic [1:0]           ALUSrcA1_0,
  output logic [1:0]           ALUSrcB1_0,
  output logic [2:0]           ImmSrc2_0,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 InstrDone,
  output logic                 IllegalInstr,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  state_t     state;
  state_t     next_state;
  logic       mem_ready;
  logic [3:0] alu_ctl;

  assign mem_ready  = MEM_WAIT_EN ? MemReady : 1'b1;
  assign State      = state;
  assign ALUControl = ALUCTRL_W'(alu_ctl);

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7,
                                            input logic op5);
    logic [3:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = (op5 & f7) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic n, input logic v, input logic c);
    logic t;
    t = 1'b0;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = ~z;
      3'b100:  t = n ^ v;
      3'b101:  t = ~(n ^ v);
      3'b110:  t = ~c;
      3'b111:  t = c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = S_FETCH;
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc1_0 = 2'b00;
    ALUSrcA1_0   = 2'b00;
    ALUSrcB1_0   = 2'b00;
    ImmSrc2_0    = IMM_I;
    alu_ctl      = ALU_ADD;
    InstrDone    = 1'b0;
    IllegalInstr = 1'b0;

    case (state)
      S_FETCH: begin
        ALUSrcB1_0   = 2'b10;
        ResultSrc1_0 = 2'b10;
        IRWrite      = mem_ready;
        PCWrite      = mem_ready;
        next_state   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA1_0 = 2'b01;
        ALUSrcB1_0 = 2'b01;
        ImmSrc2_0  = (OP6_0 == OP_JAL) ? IMM_J : IMM_B;
        case (OP6_0)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_JAL:            next_state = S_JUMP;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          // funct3 010/011 are not branch encodings in RV32I
          OP_BRANCH: begin
            if (funct3_2_0[2:1] == 2'b01) IllegalInstr = 1'b1;
            else                          next_state   = S_BRANCH;
          end
          default:           IllegalInstr = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA1_0 = 2'b10;
        ALUSrcB1_0 = 2'b01;
        ImmSrc2_0  = OP6_0[5] ? IMM_S : IMM_I;
        next_state = OP6_0[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc1_0 = 2'b01;
        RegWrite     = 1'b1;
        InstrDone    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        InstrDone  = mem_ready;
        next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA1_0 = 2'b10;
        alu_ctl    = alu_decode(funct3_2_0, funct7_5, OP6_0[5]);
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA1_0 = 2'b10;
        ALUSrcB1_0 = 2'b01;
        alu_ctl    = alu_decode(funct3_2_0, funct7_5, OP6_0[5]);
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA1_0 = 2'b10;
        alu_ctl    = ALU_SUB;
        PCWrite    = branch_taken(funct3_2_0, Zero, Negative, Overflow, Carry);
        InstrDone  = 1'b1;
      end
      S_JUMP: begin
        // PC takes the target held in ALUOut while ALU forms OldPC+4 for rd
        ALUSrcA1_0 = 2'b01;
        ALUSrcB1_0 = 2'b10;
        PCWrite    = 1'b1;
        next_state = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA1_0 = 2'b10;
        ALUSrcB1_0 = 2'b01;
        next_state = S_JUMP;
      end
      S_LUI: begin
        ALUSrcA1_0 = 2'b11;
        ALUSrcB1_0 = 2'b01;
        ImmSrc2_0  = IMM_U;
        next_state = S_ALUWB;
      end
      default: begin
        ALUSrcB1_0   = 2'b10;
        ResultSrc1_0 = 2'b10;
      end
    endcase

    if (RST) begin
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      MemWrite     = 1'b0;
      AdrSrc       = 1'b0;
      ResultSrc1_0 = 2'b00;
      ALUSrcA1_0   = 2'b00;
      ALUSrcB1_0   = 2'b00;
      ImmSrc2_0    = IMM_I;
      alu_ctl      = ALU_ADD;
      InstrDone    = 1'b0;
      IllegalInstr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed cycle-by-cycle bench for multicycle_control_fsm; every cycle's
// expected state and control word is written out by hand.
module tb_multicycle_control_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] OP6_0;
  logic [2:0] funct3_2_0;
  logic       funct7_5;
  logic       Zero, Negative, Overflow, Carry;
  logic       MemReady;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ResultSrc1_0, ALUSrcA1_0, ALUSrcB1_0;
  logic [2:0] ImmSrc2_0;
  logic [3:0] ALUControl;
  logic       InstrDone, IllegalInstr;
  logic [3:0] State;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // R-type ALUControl for funct3 0..7 with funct7_5=0
  logic [3:0] rtab [8] = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};

  multicycle_control_fsm #(.ALUCTRL_W(4), .MEM_WAIT_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .OP6_0(OP6_0), .funct3_2_0(funct3_2_0), .funct7_5(funct7_5),
    .Zero(Zero), .Negative(Negative), .Overflow(Overflow), .Carry(Carry),
    .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc1_0(ResultSrc1_0),
    .ALUSrcA1_0(ALUSrcA1_0), .ALUSrcB1_0(ALUSrcB1_0), .ImmSrc2_0(ImmSrc2_0),
    .ALUControl(ALUControl), .InstrDone(InstrDone), .IllegalInstr(IllegalInstr),
    .State(State)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // en = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, InstrDone, IllegalInstr}
  task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [6:0] en,
                              input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [2:0] imm, input logic [3:0] alu);
    @(negedge CLK);
    check_eq({tag, ".state"}, State, st);
    check_eq({tag, ".en"}, {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, InstrDone, IllegalInstr}, en);
    check_eq({tag, ".rs"}, ResultSrc1_0, rs);
    check_eq({tag, ".srca"}, ALUSrcA1_0, sa);
    check_eq({tag, ".srcb"}, ALUSrcB1_0, sb);
    check_eq({tag, ".imm"}, ImmSrc2_0, imm);
    check_eq({tag, ".alu"}, ALUControl, alu);
    @(posedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    OP6_0 = op; funct3_2_0 = f3; funct7_5 = f7;
  endtask

  task automatic fetch_cycle(input string t);
    expect_cycle({t, ".F"}, 4'd0, 7'b1100000, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0);
  endtask

  task automatic fetch_wait(input string t);
    expect_cycle({t, ".Fw"}, 4'd0, 7'b0000000, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0);
  endtask

  task automatic decode_cycle(input string t, input logic [2:0] imm, input logic [6:0] en);
    expect_cycle({t, ".D"}, 4'd1, en, 2'b00, 2'b01, 2'b01, imm, 4'd0);
  endtask

  task automatic aluwb_cycle(input string t);
    expect_cycle({t, ".WB"}, 4'd8, 7'b0010010, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);
  endtask

  task automatic branch_seq(input string t, input logic [2:0] f3, input logic taken);
    set_instr(7'b1100011, f3, 1'b0);
    fetch_cycle(t);
    decode_cycle(t, 3'b010, 7'b0);
    expect_cycle({t, ".BR"}, 4'd9, {taken, 6'b000010}, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; MemReady = 1'b1;
    Zero = 1'b0; Negative = 1'b0; Overflow = 1'b0; Carry = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0);
    @(posedge CLK); #1;
    expect_cycle("rst", 4'd0, 7'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);
    RST = 1'b0;

    // add / sub / addi with f7_5=1 / srai
    set_instr(7'b0110011, 3'b000, 1'b0);
    fetch_cycle("add"); decode_cycle("add", 3'b010, 7'b0);
    expect_cycle("add.EX", 4'd6, 7'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd0);
    aluwb_cycle("add");

    set_instr(7'b0110011, 3'b000, 1'b1);
    fetch_cycle("sub"); decode_cycle("sub", 3'b010, 7'b0);
    expect_cycle("sub.EX", 4'd6, 7'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1);
    aluwb_cycle("sub");

    set_instr(7'b0010011, 3'b000, 1'b1);
    fetch_cycle("addi"); decode_cycle("addi", 3'b010, 7'b0);
    expect_cycle("addi.EX", 4'd7, 7'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0);
    aluwb_cycle("addi");

    set_instr(7'b0010011, 3'b101, 1'b1);
    fetch_cycle("srai"); decode_cycle("srai", 3'b010, 7'b0);
    expect_cycle("srai.EX", 4'd7, 7'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd8);
    aluwb_cycle("srai");

    for (int i = 0; i < 8; i++) begin
      set_instr(7'b0110011, 3'(i), 1'b0);
      fetch_cycle($sformatf("r%0d", i));
      decode_cycle($sformatf("r%0d", i), 3'b010, 7'b0);
      expect_cycle($sformatf("r%0d.EX", i), 4'd6, 7'b0, 2'b00, 2'b10, 2'b00, 3'b000, rtab[i]);
      aluwb_cycle($sformatf("r%0d", i));
    end

    // lw: 2 fetch waits, 3 memread waits -> 10 cycles
    set_instr(7'b0000011, 3'b010, 1'b0);
    MemReady = 1'b0; fetch_wait("lw1"); fetch_wait("lw2");
    MemReady = 1'b1; fetch_cycle("lw");
    decode_cycle("lw", 3'b010, 7'b0);
    expect_cycle("lw.MA", 4'd2, 7'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0);
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++)
      expect_cycle($sformatf("lw.MRw%0d", i), 4'd3, 7'b0000100, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);
    MemReady = 1'b1;
    expect_cycle("lw.MR", 4'd3, 7'b0000100, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);
    expect_cycle("lw.MWB", 4'd4, 7'b0010010, 2'b01, 2'b00, 2'b00, 3'b000, 4'd0);

    // sw with one wait in MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0);
    fetch_cycle("sw"); decode_cycle("sw", 3'b010, 7'b0);
    expect_cycle("sw.MA", 4'd2, 7'b0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0);
    MemReady = 1'b0;
    expect_cycle("sw.MWw", 4'd5, 7'b0001100, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);
    MemReady = 1'b1;
    expect_cycle("sw.MW", 4'd5, 7'b0001110, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);

    // sw aborted by reset while MemWrite is held
    fetch_cycle("swr"); decode_cycle("swr", 3'b010, 7'b0);
    expect_cycle("swr.MA", 4'd2, 7'b0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0);
    MemReady = 1'b0;
    expect_cycle("swr.MWw", 4'd5, 7'b0001100, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);
    RST = 1'b1;
    expect_cycle("swr.rst", 4'd5, 7'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);
    RST = 1'b0; MemReady = 1'b1;

    Zero = 1'b1;
    branch_seq("bne", 3'b001, 1'b0);
    Zero = 1'b0; Negative = 1'b1; Overflow = 1'b0;
    branch_seq("blt", 3'b100, 1'b1);
    Negative = 1'b0; Carry = 1'b0;
    branch_seq("bgeu", 3'b111, 1'b0);
    Carry = 1'b1;
    branch_seq("bgeu1", 3'b111, 1'b1);
    Carry = 1'b0;

    set_instr(7'b1100111, 3'b000, 1'b0);
    fetch_cycle("jalr"); decode_cycle("jalr", 3'b010, 7'b0);
    expect_cycle("jalr.JR", 4'd11, 7'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0);
    expect_cycle("jalr.J", 4'd10, 7'b1000000, 2'b00, 2'b01, 2'b10, 3'b000, 4'd0);
    aluwb_cycle("jalr");

    set_instr(7'b1101111, 3'b000, 1'b0);
    fetch_cycle("jal"); decode_cycle("jal", 3'b011, 7'b0);
    expect_cycle("jal.J", 4'd10, 7'b1000000, 2'b00, 2'b01, 2'b10, 3'b000, 4'd0);
    aluwb_cycle("jal");

    set_instr(7'b0110111, 3'b000, 1'b0);
    fetch_cycle("lui"); decode_cycle("lui", 3'b010, 7'b0);
    expect_cycle("lui.U", 4'd12, 7'b0, 2'b00, 2'b11, 2'b01, 3'b100, 4'd0);
    aluwb_cycle("lui");

    set_instr(7'b1111111, 3'b000, 1'b0);
    fetch_cycle("ill"); decode_cycle("ill", 3'b010, 7'b0000001);

    set_instr(7'b1100011, 3'b010, 1'b0);
    fetch_cycle("illbr"); decode_cycle("illbr", 3'b010, 7'b0000001);

    set_instr(7'b0110011, 3'b111, 1'b0);
    fetch_cycle("and");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
